// File: rtl/bus_scheduler_if.sv
// Bus-time scheduler handshake bundle: channel request/grant/ack plus the
// CPU timing strobes and slot index. Signal suffixes are from the
// scheduler's point of view.
interface bus_scheduler_if #(
  parameter int NUM_CH = 2,
  parameter int SLOT_W = 1
);
  logic [NUM_CH-1:0] req_i;
  logic              cpu_pause_i;
  logic [NUM_CH-1:0] grant_o;
  logic [NUM_CH-1:0] ack_o;
  logic              cpu_en_o;
  logic              cpu_clk_o;
  logic              cpu_be_o;
  logic              strobe_o;
  logic              latch_o;
  logic [SLOT_W-1:0] slot_o;

  modport slave (
    input  req_i, cpu_pause_i,
    output grant_o, ack_o, cpu_en_o, cpu_clk_o, cpu_be_o,
           strobe_o, latch_o, slot_o
  );

  modport master (
    output req_i, cpu_pause_i,
    input  grant_o, ack_o, cpu_en_o, cpu_clk_o, cpu_be_o,
           strobe_o, latch_o, slot_o
  );
endinterface

// File: rtl/bus_scheduler.sv
// Bus-time scheduler: fixed-length slots grouped into frames. Slot 0 is the
// CPU slot unless paused; the other slots are shared round-robin among the
// bus-master channels. All outputs are registered from the next-state
// phase/slot/owner, so they line up exactly with the slot they describe.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   IDLE_SLOT | nobody owns the bus; strobe still runs, no latch
//   CPU_SLOT  | CPU owns the slot; cpu_en high, phi2 in second half
//   CH_SLOT   | channel ch_q owns the slot; ack on the last phase
module bus_scheduler #(
  parameter int SLOT_CLOCKS = 4,
  parameter int FRAME_SLOTS = 2,
  parameter int NUM_CH      = 2
) (
  input  logic clk_sys_i,
  input  logic reset_ni,
  bus_scheduler_if.slave bus
);

  localparam int PW = $clog2(SLOT_CLOCKS);
  localparam int SW = (FRAME_SLOTS > 2) ? $clog2(FRAME_SLOTS) : 1;
  localparam int CW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  localparam logic [PW-1:0] PH_LAST   = PW'(SLOT_CLOCKS - 1);
  localparam logic [PW-1:0] PH_HALF   = PW'(SLOT_CLOCKS / 2);
  localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME_SLOTS - 1);

  typedef enum logic [1:0] {IDLE_SLOT, CPU_SLOT, CH_SLOT} owner_e;

  logic [PW-1:0]     phase_q, phase_d;
  logic [SW-1:0]     slot_q, slot_d;
  owner_e            owner_q, owner_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              cpu_en_q, cpu_en_d;
  logic              cpu_clk_q, cpu_clk_d;
  logic              cpu_be_q, cpu_be_d;
  logic              strobe_q, strobe_d;
  logic              latch_q, latch_d;

  logic [NUM_CH-1:0] req_eff;
  logic [CW-1:0]     idx_v;
  logic              found;

  // State and output registers; reset parks at the last phase of the last
  // slot so the first released edge enters slot 0, phase 0.
  always_ff @(posedge clk_sys_i) begin
    if (!reset_ni) begin
      phase_q   <= PH_LAST;
      slot_q    <= SLOT_LAST;
      owner_q   <= IDLE_SLOT;
      ch_q      <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      cpu_en_q  <= 1'b0;
      cpu_clk_q <= 1'b0;
      cpu_be_q  <= 1'b1;
      strobe_q  <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      slot_q    <= slot_d;
      owner_q   <= owner_d;
      ch_q      <= ch_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      cpu_en_q  <= cpu_en_d;
      cpu_clk_q <= cpu_clk_d;
      cpu_be_q  <= cpu_be_d;
      strobe_q  <= strobe_d;
      latch_q   <= latch_d;
    end
  end

  // Counters, owner decision at the slot boundary, and next outputs.
  always_comb begin
    phase_d   = phase_q + PW'(1);
    slot_d    = slot_q;
    owner_d   = owner_q;
    ch_d      = ch_q;
    rr_d      = rr_q;
    found     = 1'b0;
    idx_v     = '0;
    // A channel being acked this clock must not be re-granted on a stale req.
    req_eff   = bus.req_i & ~ack_q;

    if (phase_q == PH_LAST) begin
      phase_d = '0;
      slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
      if (slot_d == '0 && !bus.cpu_pause_i) begin
        owner_d = CPU_SLOT;
      end else begin
        owner_d = IDLE_SLOT;
        for (int i = 0; i < NUM_CH; i++) begin
          idx_v = CW'((int'(rr_q) + i) % NUM_CH);
          if (!found && req_eff[idx_v]) begin
            found   = 1'b1;
            owner_d = CH_SLOT;
            ch_d    = idx_v;
            rr_d    = CW'((int'(idx_v) + 1) % NUM_CH);
          end
        end
      end
    end

    grant_d = '0;
    if (owner_d == CH_SLOT) grant_d[ch_d] = 1'b1;
    ack_d     = (phase_d == PH_LAST) ? grant_d : '0;
    cpu_en_d  = (owner_d == CPU_SLOT);
    cpu_clk_d = cpu_en_d && (phase_d >= PH_HALF);
    cpu_be_d  = (owner_d != CH_SLOT);
    strobe_d  = (phase_d != '0) && (phase_d != PH_LAST);
    latch_d   = (phase_d == PH_LAST) && (owner_d != IDLE_SLOT);
  end

  assign bus.grant_o   = grant_q;
  assign bus.ack_o     = ack_q;
  assign bus.cpu_en_o  = cpu_en_q;
  assign bus.cpu_clk_o = cpu_clk_q;
  assign bus.cpu_be_o  = cpu_be_q;
  assign bus.strobe_o  = strobe_q;
  assign bus.latch_o   = latch_q;
  assign bus.slot_o    = slot_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed bench for bus_scheduler: a vector table for the default
// configuration plus a rule-checked run of a 5-clock, 4-slot, 3-channel build.
module tb_bus_scheduler;

  logic clk = 1'b0;
  logic rst_a_n, rst_b_n;
  always #5 clk = ~clk;

  bus_scheduler_if #(.NUM_CH(2), .SLOT_W(1)) bus_a ();
  bus_scheduler_if #(.NUM_CH(3), .SLOT_W(2)) bus_b ();

  bus_scheduler #(.SLOT_CLOCKS(4), .FRAME_SLOTS(2), .NUM_CH(2)) dut_a (
    .clk_sys_i(clk), .reset_ni(rst_a_n), .bus(bus_a.slave));

  bus_scheduler #(.SLOT_CLOCKS(5), .FRAME_SLOTS(4), .NUM_CH(3)) dut_b (
    .clk_sys_i(clk), .reset_ni(rst_b_n), .bus(bus_b.slave));

  typedef struct {
    logic       rst_n;
    logic       pause;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] ack;
    logic [4:0] flags;  // {cpu_en, cpu_clk, cpu_be, strobe, latch}
    logic       slot;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam int K_CPU = 0, K_IDLE = 1, K_GR = 2;
  localparam logic [4:0] CPU_F  [4] = '{5'b10100, 5'b10110, 5'b11110, 5'b11101};
  localparam logic [4:0] IDLE_F [4] = '{5'b00100, 5'b00110, 5'b00110, 5'b00100};
  localparam logic [4:0] GR_F   [4] = '{5'b00000, 5'b00010, 5'b00010, 5'b00001};

  task automatic push_vec(input logic r, input logic p, input logic [1:0] rq,
                          input logic [1:0] g, input logic [1:0] a,
                          input logic [4:0] f, input logic s);
    vec_t v;
    v.rst_n = r; v.pause = p; v.req = rq; v.grant = g; v.ack = a;
    v.flags = f; v.slot = s;
    vecs.push_back(v);
  endtask

  // One whole slot of four vectors with constant inputs.
  task automatic push_slot(input logic p, input logic [1:0] rq, input int kind,
                           input logic [1:0] g, input logic s);
    for (int ph = 0; ph < 4; ph++) begin
      if (kind == K_CPU)       push_vec(1'b1, p, rq, 2'b00, 2'b00, CPU_F[ph], s);
      else if (kind == K_IDLE) push_vec(1'b1, p, rq, 2'b00, 2'b00, IDLE_F[ph], s);
      else                     push_vec(1'b1, p, rq, g, (ph == 3) ? g : 2'b00, GR_F[ph], s);
    end
  endtask

  logic [4:0] act_f;
  logic [2:0] exp_g3;
  logic [2:0] exp_a3;
  logic [4:0] exp_f3;
  logic [1:0] exp_s3;
  int         sb, phb;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    bus_a.req_i = '0; bus_a.cpu_pause_i = 1'b0;
    bus_b.req_i = '0; bus_b.cpu_pause_i = 1'b0;

    // reset
    push_vec(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 5'b00100, 1'b1);
    // free run, no requests
    push_slot(0, 2'b00, K_CPU, 2'b00, 0);  push_slot(0, 2'b00, K_IDLE, 2'b00, 1);
    // ch0 request held until ack
    push_slot(0, 2'b01, K_CPU, 2'b00, 0);  push_slot(0, 2'b01, K_GR, 2'b01, 1);
    // request dropped: idle shared slot
    push_slot(0, 2'b00, K_CPU, 2'b00, 0);  push_slot(0, 2'b00, K_IDLE, 2'b00, 1);
    // both requesting: rr alternates ch1, ch0
    push_slot(0, 2'b11, K_CPU, 2'b00, 0);  push_slot(0, 2'b11, K_GR, 2'b10, 1);
    push_slot(0, 2'b11, K_CPU, 2'b00, 0);  push_slot(0, 2'b11, K_GR, 2'b01, 1);
    // paused CPU: slot 0 shared too
    push_slot(1, 2'b11, K_GR, 2'b10, 0);   push_slot(1, 2'b11, K_GR, 2'b01, 1);
    // stale ch0 request right after its ack is masked -> idle slot 0
    push_slot(1, 2'b01, K_IDLE, 2'b00, 0); push_slot(1, 2'b01, K_GR, 2'b01, 1);
    // pause released: CPU slot back, then ch1 slot cut by reset at phase 2
    push_slot(0, 2'b00, K_CPU, 2'b00, 0);
    push_vec(1'b1, 1'b0, 2'b11, 2'b10, 2'b00, 5'b00000, 1'b1);
    push_vec(1'b1, 1'b0, 2'b11, 2'b10, 2'b00, 5'b00010, 1'b1);
    push_vec(1'b1, 1'b0, 2'b11, 2'b10, 2'b00, 5'b00010, 1'b1);
    push_vec(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 5'b00100, 1'b1);
    push_slot(0, 2'b11, K_CPU, 2'b00, 0);  push_slot(0, 2'b11, K_GR, 2'b01, 1);

    @(negedge clk);
    foreach (vecs[i]) begin
      rst_a_n           = vecs[i].rst_n;
      bus_a.cpu_pause_i = vecs[i].pause;
      bus_a.req_i       = vecs[i].req;
      @(posedge clk);
      @(negedge clk);
      act_f = {bus_a.cpu_en_o, bus_a.cpu_clk_o, bus_a.cpu_be_o,
               bus_a.strobe_o, bus_a.latch_o};
      n_vec++;
      if (bus_a.grant_o !== vecs[i].grant || bus_a.ack_o !== vecs[i].ack ||
          act_f !== vecs[i].flags || bus_a.slot_o !== vecs[i].slot) begin
        n_bad++;
        $display("FAIL vec%0d: got grant=%b ack=%b en/clk/be/stb/lat=%b slot=%0d, want grant=%b ack=%b en/clk/be/stb/lat=%b slot=%0d",
                 i, bus_a.grant_o, bus_a.ack_o, act_f, bus_a.slot_o,
                 vecs[i].grant, vecs[i].ack, vecs[i].flags, vecs[i].slot);
      end
    end

    // Wide build: reset value check, then two frames with all requests held.
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus_b.slot_o !== 2'd3 || bus_b.grant_o !== 3'b000 || bus_b.cpu_be_o !== 1'b1 ||
        bus_b.cpu_en_o !== 1'b0 || bus_b.strobe_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wide_reset: got slot=%0d grant=%b be=%b en=%b stb=%b, want slot=3 grant=000 be=1 en=0 stb=0",
               bus_b.slot_o, bus_b.grant_o, bus_b.cpu_be_o, bus_b.cpu_en_o, bus_b.strobe_o);
    end
    rst_b_n     = 1'b1;
    bus_b.req_i = 3'b111;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      sb  = (c / 5) % 4;
      phb = c % 5;
      exp_g3 = (sb == 0) ? 3'b000 : 3'(1 << (sb - 1));
      exp_a3 = (phb == 4) ? exp_g3 : 3'b000;
      exp_s3 = 2'(sb);
      exp_f3 = {sb == 0, sb == 0 && phb >= 2, sb == 0, phb >= 1 && phb <= 3, phb == 4};
      act_f  = {bus_b.cpu_en_o, bus_b.cpu_clk_o, bus_b.cpu_be_o,
                bus_b.strobe_o, bus_b.latch_o};
      n_vec++;
      if (bus_b.grant_o !== exp_g3 || bus_b.ack_o !== exp_a3 ||
          act_f !== exp_f3 || bus_b.slot_o !== exp_s3) begin
        n_bad++;
        $display("FAIL wide_clk%0d: got grant=%b ack=%b en/clk/be/stb/lat=%b slot=%0d, want grant=%b ack=%b en/clk/be/stb/lat=%b slot=%0d",
                 c, bus_b.grant_o, bus_b.ack_o, act_f, bus_b.slot_o,
                 exp_g3, exp_a3, exp_f3, exp_s3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_scheduler.md
# bus_scheduler

Parametrised bus-time scheduler that divides the system bus into fixed-length slots grouped into frames. Slot 0 of each frame belongs to the CPU. The remaining slots are arbitrated round-robin among NUM_CH bus-master channels (SPI bridge, video fetch, future DMA). It generates the CPU clock and bus-enable, per-slot write strobe and read-latch pulse, and per-channel grant/ack handshakes. It replaces the fixed CPU/SPI two-phase timing generator in the top level.

## Interface
- SLOT_CLOCKS, default 4: clk_sys_i cycles per slot; legal range ≥3.
- FRAME_SLOTS, default 2: slots per frame; legal range ≥2. Slot 0 is the CPU slot; slots 1..FRAME_SLOTS-1 are shared.
- NUM_CH, default 2: number of arbitrated channels; legal range ≥1.

- clk_sys_i  in  1  system clock; the only clock.
- reset_ni  in  1  synchronous, active-low reset.
- req_i  in  NUM_CH  per-channel request level; held high until the matching ack_o.
- cpu_pause_i  in  1  when high, the CPU slot is treated as a shared slot.
- grant_o  out  NUM_CH  one-hot or zero; the granted channel owns the bus for the whole current slot.
- ack_o  out  NUM_CH  one-clock pulse on the last clock of a granted slot; marks the transaction complete.
- cpu_en_o  out  1  high for the whole of a CPU-owned slot.
- cpu_clk_o  out  1  CPU phi2; high on phases SLOT_CLOCKS/2..SLOT_CLOCKS-1 of a CPU-owned slot, low otherwise.
- cpu_be_o  out  1  CPU bus enable; low for the whole of any slot with a non-zero grant_o, high otherwise.
- strobe_o  out  1  high on phases 1..SLOT_CLOCKS-2 of every slot (RAM write strobe window).
- latch_o  out  1  one-clock pulse on phase SLOT_CLOCKS-1 of any slot that is CPU-owned or granted (read-data capture).
- slot_o  out  max(1,$clog2(FRAME_SLOTS))  index of the current slot.

## Operation
- State: phase counter 0..SLOT_CLOCKS-1; slot counter 0..FRAME_SLOTS-1; round-robin pointer rr 0..NUM_CH-1; registered owner {none, CPU, channel k}.
- Counters:
  - phase increments every clock and wraps to 0 after SLOT_CLOCKS-1.
  - At that wrap, slot increments and wraps to 0 after FRAME_SLOTS-1.
- Owner decision is made on the edge that enters phase 0 and is held for the whole slot.
  - Entering slot 0 with cpu_pause_i=0: owner=CPU.
  - Entering any other slot, or slot 0 with cpu_pause_i=1: arbitrate.
- Arbitration: choose the first k in rr, rr+1, …, rr+NUM_CH-1 (mod NUM_CH) with req_i[k]=1.
  - If found: owner=k and rr←(k+1) mod NUM_CH.
  - If none: owner=none and rr is unchanged.
  - The idle slot still runs strobe_o, with cpu_be_o=1 and no latch_o.
- Ack masking: a channel whose ack_o is high in a clock has its req_i ignored in that clock. This prevents back-to-back re-grant from a stale request.
- States (owner): IDLE_SLOT, CPU_SLOT, CH_SLOT(k). Transitions occur only at slot boundaries, per the rules above.
- All outputs are registered and are pure functions of phase/slot/owner.
- Reset (reset_ni=0 at an edge):
  - phase=SLOT_CLOCKS-1, slot=FRAME_SLOTS-1, owner=none, rr=0.
  - Outputs: grant_o=0, ack_o=0, cpu_en_o=0, cpu_clk_o=0, cpu_be_o=1, strobe_o=0, latch_o=0.
  - slot_o=FRAME_SLOTS-1 (register reset value, matching the slot counter).
  - The first edge with reset_ni=1 enters slot 0, phase 0, and applies the slot-0 owner rule using cpu_pause_i at that edge.
- Reset mid-slot: the grant is withdrawn immediately with no ack_o. The channel keeps req_i high and is re-arbitrated later. This is not an error.

## Timing
- Frame length: SLOT_CLOCKS×FRAME_SLOTS clocks. CPU clock frequency: f_clk / frame length when cpu_pause_i=0.
- Grant latency: a req_i that is high on the clock before a shared-slot boundary yields grant_o on the next clock.
- Worst-case wait: NUM_CH shared slots plus the intervening CPU slots.
- ack_o coincides with latch_o and with the last clock of grant_o. grant_o falls on the following edge.
- cpu_pause_i is sampled only at the slot-0 boundary. Changes mid-frame take effect at the next frame.
- req_i dropped before ack_o is a protocol violation. The slot completes normally and ack_o still pulses.

## Test plan
Defaults apply unless stated (SLOT_CLOCKS=4, FRAME_SLOTS=2, NUM_CH=2; frame = 8 clocks).

- Free run, no requests: cpu_clk_o follows the pattern 0,0,1,1,0,0,0,0 repeating. cpu_en_o is high on clocks 0-3. cpu_be_o stays 1. strobe_o is high on phases 1-2 of both slots. latch_o pulses only at clock 3 of each frame.
- req_i=01 held until ack: grant_o=01 for clocks 4-7 with cpu_be_o=0 throughout, and ack_o[0] pulses at clock 7. Dropping req then gives an idle slot in the next frame.
- req_i=11 held continuously: shared slots alternate grants ch0, ch1, ch0, ch1. No channel is granted twice in a row.
- cpu_pause_i=1 with req_i=11 held: each slot alternates grant_o=01/10 every 4 clocks, and cpu_clk_o stays 0. After cpu_pause_i returns to 0, the CPU slot resumes at the next frame.
- reset_ni pulsed low at phase 2 of a ch1 slot: outputs take their reset values on the next clock. There is no ack_o[1]. After release, slot 0 is a CPU slot, and ch0 wins the first arbitration (rr=0).
- FRAME_SLOTS=4, NUM_CH=3, SLOT_CLOCKS=5, all requests held: each frame grants 3 shared slots in order 0, 1, 2. slot_o counts 0→3. cpu_clk_o is high on phases 2-4 of slot 0.
